// File: rtl/pla_eval_sched.sv
// Scheduler for an external combinational PLA: registers the stimulus, waits a fixed settle
// time, captures the response, and folds every captured response into an 18-bit MISR.
module pla_eval_sched #(
  parameter int          SETTLE_CYCLES = 2,
  parameter int          CNT_W         = 16,
  parameter logic [17:0] POLY          = 18'h00081
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_data,
  output logic [24:0]      pla_in,
  input  logic [17:0]      pla_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [17:0]      out_data,
  input  logic             sig_clr,
  output logic [17:0]      signature,
  output logic [CNT_W-1:0] vec_count,
  output logic             busy
);

  // state  | meaning
  // IDLE   | no vector in flight, ready for stimulus
  // SETTLE | pla_in driven, waiting for the PLA to settle
  // OUT    | response captured, waiting for the consumer
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    OUT    = 2'd2
  } state_t;

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [24:0]      pla_in_q, pla_in_d;
  logic             out_valid_q, out_valid_d;
  logic [17:0]      out_data_q, out_data_d;
  logic [17:0]      sig_q, sig_d;
  logic [CNT_W-1:0] vec_count_q, vec_count_d;

  logic accept;
  logic capture;
  logic [17:0] sig_base;

  assign in_ready = (state_q == IDLE) || ((state_q == OUT) && out_ready);
  assign accept   = in_valid && in_ready;
  assign capture  = (state_q == SETTLE) && (cnt_q == 4'd0);

  // A clear on the capture edge folds the new response into a zeroed register.
  assign sig_base = sig_clr ? 18'h00000 : sig_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pla_in_d    = pla_in_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sig_d       = sig_q;
    vec_count_d = vec_count_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          pla_in_d = in_data;
          cnt_d    = SETTLE_LOAD;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          out_data_d  = pla_out;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (accept) begin
            pla_in_d = in_data;
            cnt_d    = SETTLE_LOAD;
            state_d  = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      sig_d = (sig_base << 1) ^ (sig_base[17] ? POLY : 18'h00000) ^ pla_out;
      if (vec_count_q != {CNT_W{1'b1}}) begin
        vec_count_d = vec_count_q + CNT_ONE;
      end
    end else if (sig_clr) begin
      sig_d = 18'h00000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      pla_in_q    <= 25'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 18'd0;
      sig_q       <= 18'd0;
      vec_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pla_in_q    <= pla_in_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sig_q       <= sig_d;
      vec_count_q <= vec_count_d;
    end
  end

  assign pla_in    = pla_in_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign signature = sig_q;
  assign vec_count = vec_count_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/pla_eval_sched.md
PLA_EVAL_SCHED -- requirements
Module: pla_eval_sched

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: cycles allowed for the external combinational PLA to settle; legal range 1..15.
REQ-002 SHALL have parameter CNT_W, default 16: width of the vector counter.
REQ-003 SHALL have parameter POLY, default 18'h00081: MISR feedback taps (x^18+x^7+1).
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1: stimulus vector offered.
REQ-008 SHALL have port in_ready, output, 1: block accepts the vector this cycle.
REQ-009 SHALL have port in_data, input, 25: stimulus; bit 0 = PLA input a … bit 24 = PLA input y.
REQ-010 SHALL have port pla_in, output, 25: registered drive to the external PLA.
REQ-011 SHALL have port pla_out, input, 18: PLA response, purely combinational of pla_in.
REQ-012 SHALL have port out_valid, output, 1: captured result available.
REQ-013 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-014 SHALL have port out_data, output, 18: captured PLA response.
REQ-015 SHALL have port sig_clr, input, 1: synchronous MISR clear.
REQ-016 SHALL have port signature, output, 18: running MISR over all captured responses.
REQ-017 SHALL have port vec_count, output, CNT_W: number of captured responses, saturating.
REQ-018 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, SETTLE, OUT.
REQ-020 SHALL drive in_ready = (state==IDLE) | (state==OUT & out_ready), combinationally.
REQ-021 SHALL, on an edge with in_valid & in_ready (acceptance), load pla_in <= in_data, load settle counter <= SETTLE_CYCLES-1, and enter SETTLE.
REQ-022 SHALL hold pla_in stable from acceptance until the next acceptance; pla_in never changes in SETTLE or OUT.
REQ-023 SHALL, in SETTLE with counter nonzero, decrement the counter; with counter zero, capture out_data <= pla_out, set out_valid, and enter OUT.
REQ-024 SHALL place the capture edge exactly SETTLE_CYCLES edges after the acceptance edge; out_valid rises on that edge.
REQ-025 SHALL hold out_valid and out_data stable in OUT until out_ready is high.
REQ-026 SHALL, in OUT with out_ready and no new acceptance, clear out_valid and enter IDLE; with out_ready and in_valid, clear out_valid, accept the new vector per REQ-021, and enter SETTLE (back-to-back, no idle cycle).
REQ-027 SHALL ignore in_valid in SETTLE; in_data is not sampled.
REQ-028 SHALL, on each capture, update signature <= (signature<<1) ^ (signature[17] ? POLY : 0) ^ pla_out.
REQ-029 SHALL, on sig_clr without capture, set signature <= 0; on sig_clr coinciding with capture, set signature <= pla_out (clear, then fold).
REQ-030 SHALL, on each capture, increment vec_count; it holds at 2^CNT_W-1 and does not wrap; vec_count is cleared only by reset.
REQ-031 SHALL treat out_ready while out_valid is low as no effect.

Reset
REQ-032 SHALL, on rst assertion at any time, including mid-SETTLE or in OUT, immediately enter IDLE and set pla_in=0, out_valid=0, out_data=0, signature=0, vec_count=0, settle counter=0; busy=0 and in_ready=1 while rst is low after release.
REQ-033 SHALL discard any in-flight vector on reset; no capture occurs for it.
REQ-034 SHALL accept a vector on the first rising edge after rst deasserts when in_valid is high.

Verification
REQ-035 SHALL be tested with default params and a stub PLA pla_out = pla_in[17:0] ^ 18'h3FFFF: accept in_data=25'h0000005 with out_ready=1 -> out_valid high exactly 2 edges after acceptance, out_data=18'h3FFFA, vec_count=1, signature=18'h3FFFA.
REQ-036 SHALL be tested with out_ready held low for 5 cycles after capture -> out_valid and out_data stable, in_ready=0, pla_in unchanged; then out_ready=1 with in_valid=1 -> new acceptance on that edge, and out_valid low the next cycle.
REQ-037 SHALL be tested with SETTLE_CYCLES=1 and 3 back-to-back vectors, with out_ready=1 and in_valid=1 held -> one result every 2 cycles, vec_count=3.
REQ-038 SHALL be tested with sig_clr asserted on the capture edge of a vector whose response is 18'h00123 -> signature=18'h00123; sig_clr alone -> signature=0.
REQ-039 SHALL be tested with rst pulsed one cycle after acceptance -> out_valid never rises for that vector, all outputs zero, busy=0, in_ready=1.
REQ-040 SHALL be tested with CNT_W=2 and 5 captures -> vec_count sticks at 3.
